// File: rtl/brg_wb2ps_wbrf_seq_pkg.sv
// Shared definitions for the PSRAM cache write-back / read-fill sequencer:
// line geometry, address field widths, FSM encoding and the latched job record.
package brg_wb2ps_wbrf_seq_pkg;

    localparam int unsigned LINE_WORDS = 16;
    localparam int unsigned WAYS       = 4;
    localparam int unsigned TAG_W      = 13;
    localparam int unsigned LINE_W     = 4;
    localparam int unsigned WORD_W     = 4;
    localparam int unsigned PS_ADR_W   = TAG_W + LINE_W + WORD_W;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StWbCmd  = 3'd1,
        StWbData = 3'd2,
        StRfCmd  = 3'd3,
        StRfData = 3'd4,
        StDone   = 3'd5
    } seq_state_e;

    typedef struct packed {
        logic [WAYS-1:0]   way;
        logic [LINE_W-1:0] line;
        logic [TAG_W-1:0]  wb_tag;
        logic [TAG_W-1:0]  rf_tag;
        logic [31:0]       ow_data;
        logic [3:0]        ow_strb;
        logic [WORD_W-1:0] ow_lsb;
        logic              ow_valid;
        logic              is_wb;
    } seq_job_t;

endpackage

// File: rtl/brg_wb2ps_wbrf_seq.sv
// Write-back / read-fill sequencer: streams a victim line from data RAM to PSRAM (WB jobs),
// then refills the line from PSRAM, merging the pending miss-write word into the fill stream.
module brg_wb2ps_wbrf_seq
    import brg_wb2ps_wbrf_seq_pkg::*;
#(
    parameter int unsigned BURST_RNUM = 8
) (
    input  logic                cpuclk,
    input  logic                WSHRST,
    input  logic                WB_RUN,
    input  logic                RFILL_RUN,
    input  logic [WAYS-1:0]     WB_w_wayno,
    input  logic [LINE_W-1:0]   WB_w_lineno,
    input  logic [TAG_W-1:0]    WB_w_tagadr,
    input  logic [TAG_W-1:0]    RF_w_tagadr,
    input  logic [31:0]         OW_w_data,
    input  logic [3:0]          OW_w_strb,
    input  logic [WORD_W-1:0]   OW_w_adr_lsb,
    input  logic                OW_w_wvalid,
    output logic                WB_RUN_CLR_cpuclk_r,
    output logic                RFILL_RUN_CLR_cpuclk_r,
    output logic [WAYS-1:0]     dc_rd_way,
    output logic [7:0]          dc_rd_adr,
    input  logic [31:0]         dc_rd_data,
    output logic [WAYS-1:0]     dc_wr_en,
    output logic [7:0]          dc_wr_adr,
    output logic [31:0]         dc_wr_data,
    output logic [3:0]          dc_wr_strb,
    output logic                ps_req,
    output logic                ps_we,
    output logic [PS_ADR_W-1:0] ps_adr,
    input  logic                ps_ack,
    input  logic                ps_wready,
    output logic [31:0]         ps_wdata,
    input  logic                ps_rvalid,
    input  logic [31:0]         ps_rdata,
    output logic                busy,
    output logic [31:0]         wb_cnt,
    output logic [31:0]         rf_cnt
);

    localparam logic [WORD_W-1:0] BURST_MASK = WORD_W'(BURST_RNUM - 1);
    localparam logic [WORD_W-1:0] LAST_WORD  = WORD_W'(LINE_WORDS - 1);

    seq_state_e        r_state;
    seq_state_e        w_state_nxt;
    seq_job_t          r_job;
    seq_job_t          w_job_in;
    logic [WORD_W-1:0] r_wcnt;
    logic [WORD_W-1:0] w_wcnt_inc;
    logic              r_hold;
    logic [31:0]       r_wb_cnt;
    logic [31:0]       r_rf_cnt;
    logic              w_take;
    logic              w_burst_end;
    logic              w_last;
    logic              w_start;

    function automatic logic [31:0] merge_bytes(input logic [31:0] base,
                                                input logic [31:0] ow,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = base;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = ow[8*i +: 8];
        end
        return res;
    endfunction

    assign w_job_in = '{
        way:      WB_w_wayno,
        line:     WB_w_lineno,
        wb_tag:   WB_w_tagadr,
        rf_tag:   RF_w_tagadr,
        ow_data:  OW_w_data,
        ow_strb:  OW_w_strb,
        ow_lsb:   OW_w_adr_lsb,
        ow_valid: OW_w_wvalid,
        is_wb:    WB_RUN
    };

    assign w_take      = ((r_state == StWbData) && ps_wready) ||
                         ((r_state == StRfData) && ps_rvalid);
    assign w_wcnt_inc  = r_wcnt + 4'd1;
    assign w_burst_end = (w_wcnt_inc & BURST_MASK) == '0;
    assign w_last      = (r_wcnt == LAST_WORD);
    assign w_start     = (r_state == StIdle) && (w_state_nxt != StIdle);

    always_ff @(posedge cpuclk or posedge WSHRST) begin
        if (WSHRST) begin
            r_state  <= StIdle;
            r_job    <= '0;
            r_wcnt   <= '0;
            r_hold   <= 1'b0;
            r_wb_cnt <= '0;
            r_rf_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            // RUN is only dropped by the controller at the CLR edge; skip one IDLE cycle.
            r_hold  <= (r_state == StDone);
            if (w_start) begin
                r_job  <= w_job_in;
                r_wcnt <= '0;
            end else if (w_take) begin
                r_wcnt <= w_wcnt_inc;
            end
            if (r_state == StDone) begin
                r_rf_cnt <= r_rf_cnt + 32'd1;
                if (r_job.is_wb) r_wb_cnt <= r_wb_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle: begin
                if (!r_hold) begin
                    if (WB_RUN)         w_state_nxt = StWbCmd;
                    else if (RFILL_RUN) w_state_nxt = StRfCmd;
                end
            end
            StWbCmd:  if (ps_ack) w_state_nxt = StWbData;
            StWbData: begin
                if (ps_wready) begin
                    if (w_last)           w_state_nxt = StRfCmd;
                    else if (w_burst_end) w_state_nxt = StWbCmd;
                end
            end
            StRfCmd:  if (ps_ack) w_state_nxt = StRfData;
            StRfData: begin
                if (ps_rvalid) begin
                    if (w_last)           w_state_nxt = StDone;
                    else if (w_burst_end) w_state_nxt = StRfCmd;
                end
            end
            StDone:   w_state_nxt = StIdle;
            default:  w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        ps_req                 = 1'b0;
        ps_we                  = 1'b0;
        ps_adr                 = '0;
        ps_wdata               = '0;
        dc_rd_way              = '0;
        dc_rd_adr              = '0;
        dc_wr_en               = '0;
        dc_wr_adr              = '0;
        dc_wr_data             = '0;
        dc_wr_strb             = '0;
        WB_RUN_CLR_cpuclk_r    = 1'b0;
        RFILL_RUN_CLR_cpuclk_r = 1'b0;
        busy                   = (r_state != StIdle);
        wb_cnt                 = r_wb_cnt;
        rf_cnt                 = r_rf_cnt;
        case (r_state)
            StWbCmd: begin
                ps_req    = 1'b1;
                ps_we     = 1'b1;
                ps_adr    = {r_job.wb_tag, r_job.line, r_wcnt};
                dc_rd_way = r_job.way;
                dc_rd_adr = {r_job.line, r_wcnt};
            end
            StWbData: begin
                // Look one word ahead when the current word is consumed this cycle.
                dc_rd_way = r_job.way;
                dc_rd_adr = {r_job.line, r_wcnt + {3'b000, ps_wready}};
                ps_wdata  = dc_rd_data;
            end
            StRfCmd: begin
                ps_req = 1'b1;
                ps_adr = {r_job.rf_tag, r_job.line, r_wcnt};
            end
            StRfData: begin
                if (ps_rvalid) begin
                    dc_wr_en   = r_job.way;
                    dc_wr_adr  = {r_job.line, r_wcnt};
                    dc_wr_strb = 4'hF;
                    dc_wr_data = (r_job.ow_valid && (r_wcnt == r_job.ow_lsb)) ?
                                 merge_bytes(ps_rdata, r_job.ow_data, r_job.ow_strb) : ps_rdata;
                end
            end
            StDone: begin
                WB_RUN_CLR_cpuclk_r    = r_job.is_wb;
                RFILL_RUN_CLR_cpuclk_r = !r_job.is_wb;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_brg_wb2ps_wbrf_seq.sv
// Scoreboard bench for brg_wb2ps_wbrf_seq: directed jobs push expected PSRAM commands, write
// words, data RAM writes and CLR pulses; a monitor pops and compares as the DUT presents them.
module tb_brg_wb2ps_wbrf_seq;

    localparam int BR = 8;

    logic        cpuclk = 1'b0;
    logic        WSHRST = 1'b1;
    logic        WB_RUN = 1'b0;
    logic        RFILL_RUN = 1'b0;
    logic [3:0]  WB_w_wayno = '0;
    logic [3:0]  WB_w_lineno = '0;
    logic [12:0] WB_w_tagadr = '0;
    logic [12:0] RF_w_tagadr = '0;
    logic [31:0] OW_w_data = '0;
    logic [3:0]  OW_w_strb = '0;
    logic [3:0]  OW_w_adr_lsb = '0;
    logic        OW_w_wvalid = 1'b0;
    logic        WB_RUN_CLR_cpuclk_r;
    logic        RFILL_RUN_CLR_cpuclk_r;
    logic [3:0]  dc_rd_way;
    logic [7:0]  dc_rd_adr;
    logic [31:0] dc_rd_data = '0;
    logic [3:0]  dc_wr_en;
    logic [7:0]  dc_wr_adr;
    logic [31:0] dc_wr_data;
    logic [3:0]  dc_wr_strb;
    logic        ps_req;
    logic        ps_we;
    logic [20:0] ps_adr;
    logic        ps_ack = 1'b0;
    logic        ps_wready = 1'b0;
    logic [31:0] ps_wdata;
    logic        ps_rvalid = 1'b0;
    logic [31:0] ps_rdata = '0;
    logic        busy;
    logic [31:0] wb_cnt;
    logic [31:0] rf_cnt;

    brg_wb2ps_wbrf_seq #(.BURST_RNUM(BR)) dut (
        .cpuclk                 (cpuclk),
        .WSHRST                 (WSHRST),
        .WB_RUN                 (WB_RUN),
        .RFILL_RUN              (RFILL_RUN),
        .WB_w_wayno             (WB_w_wayno),
        .WB_w_lineno            (WB_w_lineno),
        .WB_w_tagadr            (WB_w_tagadr),
        .RF_w_tagadr            (RF_w_tagadr),
        .OW_w_data              (OW_w_data),
        .OW_w_strb              (OW_w_strb),
        .OW_w_adr_lsb           (OW_w_adr_lsb),
        .OW_w_wvalid            (OW_w_wvalid),
        .WB_RUN_CLR_cpuclk_r    (WB_RUN_CLR_cpuclk_r),
        .RFILL_RUN_CLR_cpuclk_r (RFILL_RUN_CLR_cpuclk_r),
        .dc_rd_way              (dc_rd_way),
        .dc_rd_adr              (dc_rd_adr),
        .dc_rd_data             (dc_rd_data),
        .dc_wr_en               (dc_wr_en),
        .dc_wr_adr              (dc_wr_adr),
        .dc_wr_data             (dc_wr_data),
        .dc_wr_strb             (dc_wr_strb),
        .ps_req                 (ps_req),
        .ps_we                  (ps_we),
        .ps_adr                 (ps_adr),
        .ps_ack                 (ps_ack),
        .ps_wready              (ps_wready),
        .ps_wdata               (ps_wdata),
        .ps_rvalid              (ps_rvalid),
        .ps_rdata               (ps_rdata),
        .busy                   (busy),
        .wb_cnt                 (wb_cnt),
        .rf_cnt                 (rf_cnt)
    );

    initial forever #5 cpuclk = ~cpuclk;

    typedef struct packed {logic we; logic [20:0] adr;} cmd_t;
    typedef struct packed {logic [3:0] en; logic [7:0] adr; logic [31:0] data; logic [3:0] strb;} dcw_t;

    cmd_t        q_cmd[$];
    logic [31:0] q_psw[$];
    dcw_t        q_dcw[$];
    logic [1:0]  q_clr[$];

    int n_checks = 0;
    int n_fail = 0;
    int psw_seen = 0;
    bit clr_seen = 0;
    int ack_dly = 0;
    bit tog_w = 0;
    bit tog_r = 0;
    bit force_w7 = 0;
    int exp_wb_cnt = 0;
    int exp_rf_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected output %h, nothing expected (t=%0t)", name, act, $time);
    endtask

    // Data RAM contents: identifies way and word address.
    function automatic logic [31:0] ram_fn(input logic [3:0] way, input logic [7:0] adr);
        return {8'hC5, 4'h0, way, 8'h3A, adr};
    endfunction

    // PSRAM contents: identifies the word address; word 7 overridden for the merge vector.
    function automatic logic [31:0] rd_fn(input logic [20:0] a);
        if (force_w7 && a[3:0] == 4'd7) return 32'h1122_3344;
        return {11'h2A5, a};
    endfunction

    // Data RAM with one-cycle read latency.
    initial begin
        logic [3:0] rw;
        logic [7:0] ra;
        forever begin
            @(posedge cpuclk);
            rw = dc_rd_way;
            ra = dc_rd_adr;
            #1 dc_rd_data = ram_fn(rw, ra);
        end
    end

    // PSRAM burst engine model.
    initial begin
        int rem;
        int dly;
        bit active;
        bit cur_we;
        bit ph;
        logic [20:0] cur_adr;
        rem = 0; dly = 0; active = 0; cur_we = 0; ph = 0; cur_adr = '0;
        forever begin
            @(negedge cpuclk);
            if (WSHRST) begin
                ps_ack = 0; ps_wready = 0; ps_rvalid = 0;
                active = 0; rem = 0; dly = 0;
                continue;
            end
            if (ps_wready || ps_rvalid) rem--;
            ps_wready = 0;
            ps_rvalid = 0;
            if (ps_ack) begin
                ps_ack = 0;
                active = 1;
                rem = BR;
            end else if (active && rem == 0) begin
                active = 0;
            end
            if (!active && ps_req) begin
                if (dly >= ack_dly) begin
                    ps_ack = 1; cur_we = ps_we; cur_adr = ps_adr; dly = 0;
                end else begin
                    dly++;
                end
            end
            ph = !ph;
            if (active && rem > 0) begin
                if (cur_we) begin
                    ps_wready = !tog_w || ph;
                end else if (!tog_r || ph) begin
                    ps_rvalid = 1;
                    ps_rdata = rd_fn(cur_adr + 21'(BR - rem));
                end
            end
        end
    end

    // Monitor: compares every DUT output event against the scoreboard queues.
    initial begin
        bit p_req;
        bit p_ack;
        bit p_we;
        logic [20:0] p_adr;
        p_req = 0; p_ack = 0; p_we = 0; p_adr = '0;
        forever begin
            @(negedge cpuclk);
            #2;
            if (WSHRST) begin
                p_req = 0;
                continue;
            end
            if (p_req && !p_ack) chk("ps_req_hold", {ps_req, ps_we, ps_adr}, {1'b1, p_we, p_adr});
            p_req = ps_req; p_ack = ps_ack; p_we = ps_we; p_adr = ps_adr;
            if (ps_req && ps_ack) begin
                if (q_cmd.size() == 0) unexpected("ps_cmd", {ps_we, ps_adr});
                else chk("ps_cmd", {ps_we, ps_adr}, q_cmd.pop_front());
            end
            if (ps_wready) begin
                psw_seen++;
                if (q_psw.size() == 0) unexpected("ps_wdata", ps_wdata);
                else chk("ps_wdata", ps_wdata, q_psw.pop_front());
            end
            if (dc_wr_en != 4'h0) begin
                if (q_dcw.size() == 0) unexpected("dc_write", {dc_wr_en, dc_wr_adr, dc_wr_data, dc_wr_strb});
                else chk("dc_write", {dc_wr_en, dc_wr_adr, dc_wr_data, dc_wr_strb}, q_dcw.pop_front());
            end
            if (WB_RUN_CLR_cpuclk_r || RFILL_RUN_CLR_cpuclk_r) begin
                clr_seen = 1;
                if (q_clr.size() == 0) unexpected("clr", {WB_RUN_CLR_cpuclk_r, RFILL_RUN_CLR_cpuclk_r});
                else chk("clr", {WB_RUN_CLR_cpuclk_r, RFILL_RUN_CLR_cpuclk_r}, q_clr.pop_front());
            end
        end
    end

    // Push expectations; wb_a/rf_a are the hand-computed burst start addresses.
    task automatic push_job(input bit wb, input logic [3:0] way, input logic [3:0] line,
                            input logic [20:0] wb_a0, input logic [20:0] wb_a1,
                            input logic [20:0] rf_a0, input logic [20:0] rf_a1,
                            input bit owv, input logic [3:0] owlsb, input logic [31:0] owexp);
        logic [31:0] d;
        if (wb) begin
            q_cmd.push_back({1'b1, wb_a0});
            q_cmd.push_back({1'b1, wb_a1});
            for (int i = 0; i < 16; i++) q_psw.push_back(ram_fn(way, {line, 4'(i)}));
        end
        q_cmd.push_back({1'b0, rf_a0});
        q_cmd.push_back({1'b0, rf_a1});
        for (int i = 0; i < 16; i++) begin
            d = rd_fn((i < 8 ? rf_a0 : rf_a1) + 21'(i % 8));
            if (owv && 4'(i) == owlsb) d = owexp;
            q_dcw.push_back({way, line, 4'(i), d, 4'hF});
        end
        q_clr.push_back(wb ? 2'b10 : 2'b01);
    endtask

    task automatic start_job(input bit wb, input bit rf, input logic [3:0] way,
                             input logic [3:0] line, input logic [12:0] wbtag,
                             input logic [12:0] rftag, input bit owv, input logic [3:0] owlsb,
                             input logic [3:0] owstrb, input logic [31:0] owdata);
        @(negedge cpuclk);
        clr_seen = 0;
        WB_w_wayno = way; WB_w_lineno = line; WB_w_tagadr = wbtag; RF_w_tagadr = rftag;
        OW_w_wvalid = owv; OW_w_adr_lsb = owlsb; OW_w_strb = owstrb; OW_w_data = owdata;
        WB_RUN = wb; RFILL_RUN = rf;
        @(negedge cpuclk);
        // Controller registers move on; the DUT must work from its latched copy.
        WB_w_wayno = ~way; WB_w_lineno = ~line; WB_w_tagadr = ~wbtag; RF_w_tagadr = ~rftag;
        OW_w_wvalid = !owv; OW_w_adr_lsb = ~owlsb; OW_w_strb = ~owstrb; OW_w_data = ~owdata;
    endtask

    task automatic finish_job(input string name);
        int n;
        n = 0;
        while (!clr_seen && n < 4000) begin
            @(negedge cpuclk);
            n++;
        end
        if (!clr_seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: no CLR pulse within 4000 cycles", name);
        end
        // RUN stays high through the IDLE cycle after DONE, as the real controller does.
        @(negedge cpuclk);
        WB_RUN = 0;
        RFILL_RUN = 0;
        repeat (2) @(negedge cpuclk);
        chk({name, "_idle_after"}, busy, 1'b0);
        chk({name, "_cmd_q_left"}, q_cmd.size(), 0);
        chk({name, "_psw_q_left"}, q_psw.size(), 0);
        chk({name, "_dcw_q_left"}, q_dcw.size(), 0);
        chk({name, "_clr_q_left"}, q_clr.size(), 0);
        chk({name, "_wb_cnt"}, wb_cnt, 32'(exp_wb_cnt));
        chk({name, "_rf_cnt"}, rf_cnt, 32'(exp_rf_cnt));
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_ps"}, {ps_req, ps_we, ps_adr, ps_wdata}, 0);
        chk({name, "_dc_rd"}, {dc_rd_way, dc_rd_adr}, 0);
        chk({name, "_dc_wr"}, {dc_wr_en, dc_wr_adr, dc_wr_data, dc_wr_strb}, 0);
        chk({name, "_clr"}, {WB_RUN_CLR_cpuclk_r, RFILL_RUN_CLR_cpuclk_r}, 0);
        chk({name, "_cnt"}, {wb_cnt, rf_cnt}, 0);
    endtask

    initial begin
        int n;
        #2;
        chk_outputs_zero("reset");
        @(negedge cpuclk);
        WSHRST = 0;

        // Fill only: way2, line 3, tag 0x12 -> bursts at {0x12,3,0}=0x01230 and 0x01238.
        push_job(0, 4'b0100, 4'h3, '0, '0, 21'h01230, 21'h01238, 0, 4'h0, 32'h0);
        exp_rf_cnt++;
        start_job(0, 1, 4'b0100, 4'h3, 13'h0000, 13'h0012, 0, 4'h0, 4'h0, 32'h0);
        finish_job("rfill");

        // Write-back: tag 0x1, line 5 -> 0x00150/0x00158, then fill from tag 0x20.
        push_job(1, 4'b0001, 4'h5, 21'h00150, 21'h00158, 21'h02050, 21'h02058, 0, 4'h0, 32'h0);
        exp_wb_cnt++; exp_rf_cnt++;
        start_job(1, 0, 4'b0001, 4'h5, 13'h0001, 13'h0020, 0, 4'h0, 4'h0, 32'h0);
        finish_job("wb");

        // Write miss: byte merge of 0xAABBCCDD (strb 0011) into 0x11223344 at word 7.
        force_w7 = 1;
        push_job(0, 4'b1000, 4'hA, '0, '0, 21'h007A0, 21'h007A8, 1, 4'h7, 32'h1122_CCDD);
        exp_rf_cnt++;
        start_job(0, 1, 4'b1000, 4'hA, 13'h0000, 13'h0007, 1, 4'h7, 4'b0011, 32'hAABB_CCDD);
        finish_job("merge");
        force_w7 = 0;

        // Throttled handshakes: ack after 5 cycles, wready/rvalid every other cycle.
        ack_dly = 5; tog_w = 1; tog_r = 1;
        push_job(1, 4'b0010, 4'hC, 21'h1ABCC0, 21'h1ABCC8, 21'h0FFFC0, 21'h0FFFC8, 0, 4'h0, 32'h0);
        exp_wb_cnt++; exp_rf_cnt++;
        start_job(1, 0, 4'b0010, 4'hC, 13'h1ABC, 13'h0FFF, 0, 4'h0, 4'h0, 32'h0);
        finish_job("throttle");
        ack_dly = 0; tog_w = 0; tog_r = 0;

        // Both RUN bits: write-back path wins, only the WB CLR pulses.
        push_job(1, 4'b0001, 4'h2, 21'h0F020, 21'h0F028, 21'h03320, 21'h03328, 0, 4'h0, 32'h0);
        exp_wb_cnt++; exp_rf_cnt++;
        start_job(1, 1, 4'b0001, 4'h2, 13'h00F0, 13'h0033, 0, 4'h0, 4'h0, 32'h0);
        finish_job("both");

        // Reset during write-back word 9: job abandoned, no CLR, counters cleared.
        push_job(1, 4'b0100, 4'h9, 21'h05590, 21'h05598, 21'h00190, 21'h00198, 0, 4'h0, 32'h0);
        n = psw_seen;
        start_job(1, 0, 4'b0100, 4'h9, 13'h0055, 13'h0001, 0, 4'h0, 4'h0, 32'h0);
        while (psw_seen - n < 9 && psw_seen - n >= 0 && n >= 0) begin
            @(negedge cpuclk);
            if (psw_seen == n && busy == 0) break;
        end
        chk("rst_reached_word9", psw_seen - n, 9);
        #1 WSHRST = 1;
        WB_RUN = 0;
        #1 chk_outputs_zero("midrst");
        q_cmd.delete(); q_psw.delete(); q_dcw.delete(); q_clr.delete();
        exp_wb_cnt = 0; exp_rf_cnt = 0;
        repeat (3) @(negedge cpuclk);
        chk("midrst_no_clr", clr_seen, 0);
        WSHRST = 0;
        repeat (3) @(negedge cpuclk);
        chk("midrst_idle", busy, 0);

        push_job(0, 4'b0100, 4'h1, '0, '0, 21'h10110, 21'h10118, 0, 4'h0, 32'h0);
        exp_rf_cnt++;
        start_job(0, 1, 4'b0100, 4'h1, 13'h0000, 13'h0101, 0, 4'h0, 4'h0, 32'h0);
        finish_job("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
